// File: rtl/uart_rx_fifo_if.sv
// Bus bundle between the UART receiver/register block and uart_rx_fifo.
// The slave modport is the FIFO; the master modport is the receiver + register side.
interface uart_rx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  baudRateX16Tick;
    logic [7:0]            rxData;
    logic                  rxWe;
    logic                  rxFrameError;
    logic                  rxParityError;
    logic                  rxBreak;
    logic                  fifoClear;
    logic [1:0]            triggerLevel;
    logic                  readAck;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [DEPTH_LOG2:0]   fillCount;
    logic [7:0]            readData;
    logic [2:0]            readError;
    logic                  errorInFifo;
    logic                  triggerIrq;
    logic                  timeoutIrq;

    modport master (
        output baudRateX16Tick, rxData, rxWe, rxFrameError, rxParityError, rxBreak,
        output fifoClear, triggerLevel, readAck,
        input  fifoFull, fifoEmpty, fillCount, readData, readError,
        input  errorInFifo, triggerIrq, timeoutIrq
    );

    modport slave (
        input  baudRateX16Tick, rxData, rxWe, rxFrameError, rxParityError, rxBreak,
        input  fifoClear, triggerLevel, readAck,
        output fifoFull, fifoEmpty, fillCount, readData, readError,
        output errorInFifo, triggerIrq, timeoutIrq
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO (first-word-fall-through) with error tracking and interrupts.
// Define UART_RX_FIFO_TIMEOUT_EN to build the character-timeout counter and timeoutIrq.
module uart_rx_fifo #(
    parameter int DEPTH_LOG2    = 4,
    parameter int TIMEOUT_TICKS = 640
) (
    input  logic            clock,
    input  logic            reset,
    uart_rx_fifo_if.slave   bus
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [10:0]           r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_fill_count;
    logic [DEPTH_LOG2:0]   r_error_count;

    logic        w_full;
    logic        w_empty;
    logic        w_push;
    logic        w_pop;
    logic [10:0] w_head;
    logic        w_push_err;
    logic        w_pop_err;
    logic [31:0] w_threshold;

    assign w_full     = (r_fill_count == FULL_COUNT);
    assign w_empty    = (r_fill_count == '0);
    assign w_pop      = bus.readAck && !w_empty;
    // At full, a simultaneous pop frees the slot so the push still lands.
    assign w_push     = bus.rxWe && (!w_full || w_pop);
    assign w_head     = r_mem[r_rd_ptr];
    assign w_push_err = bus.rxBreak || bus.rxParityError || bus.rxFrameError;
    assign w_pop_err  = |w_head[10:8];

    // Array contents are never reset; visibility is governed by the pointers and count.
    always_ff @(posedge clock) begin
        if (!reset && !bus.fifoClear && w_push) begin
            r_mem[r_wr_ptr] <= {bus.rxBreak, bus.rxParityError, bus.rxFrameError, bus.rxData};
        end
    end

    always_ff @(posedge clock) begin
        if (reset || bus.fifoClear) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_fill_count  <= '0;
            r_error_count <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_fill_count <= r_fill_count + 1'b1;
                2'b01:   r_fill_count <= r_fill_count - 1'b1;
                default: r_fill_count <= r_fill_count;
            endcase
            case ({w_push && w_push_err, w_pop && w_pop_err})
                2'b10:   r_error_count <= r_error_count + 1'b1;
                2'b01:   r_error_count <= r_error_count - 1'b1;
                default: r_error_count <= r_error_count;
            endcase
        end
    end

    always_comb begin
        w_threshold = 32'd1;
        case (bus.triggerLevel)
            2'd0:    w_threshold = 32'd1;
            2'd1:    w_threshold = 32'd4;
            2'd2:    w_threshold = 32'd8;
            default: w_threshold = 32'd14;
        endcase
    end

    assign bus.fifoFull    = w_full;
    assign bus.fifoEmpty   = w_empty;
    assign bus.fillCount   = r_fill_count;
    assign bus.readData    = w_empty ? 8'h00 : w_head[7:0];
    assign bus.readError   = w_empty ? 3'b000 : w_head[10:8];
    assign bus.errorInFifo = (r_error_count != '0);
    assign bus.triggerIrq  = (32'(r_fill_count) >= w_threshold);

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);

    logic [TW-1:0] r_timeout_cnt;
    logic          r_timeout_irq;

    // Any FIFO activity, or nothing stored, restarts the idle measurement.
    always_ff @(posedge clock) begin
        if (reset || bus.fifoClear || w_push || w_pop || w_empty) begin
            r_timeout_cnt <= '0;
            r_timeout_irq <= 1'b0;
        end else if (bus.baudRateX16Tick && !r_timeout_irq) begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
            if (r_timeout_cnt == TIMEOUT_LAST) r_timeout_irq <= 1'b1;
        end
    end

    assign bus.timeoutIrq = r_timeout_irq;
`else
    assign bus.timeoutIrq = 1'b0;
`endif
endmodule
